// File: rtl/multi_receiver_collector.sv
// Round-robin collector of decoded lighthouse words from NB_RECEIVERS BMC
// decoders into one shared circular buffer, read by index and popped by host.
// Ports: clk_96MHz, reset_n (async, active-low);
//   decoded_data / ts_decoded_data / decoded_data_avl : per-channel inputs,
//     channel 0 in the LSBs;
//   reset_bmc_decoder : one-cycle clear pulse to the granted decoder;
//   block_wanted_number, block_pop : host read index and retire strobe;
//   block_wanted {ch,data,ts}, data_ready, avl_blocks_nb, overflow_cnt : status.
module multi_receiver_collector #(
    parameter int NB_RECEIVERS = 4,
    parameter int DATA_WIDTH   = 17,
    parameter int TS_WIDTH     = 24,
    parameter int DEPTH        = 32,
    parameter bit DROP_OLDEST  = 1'b0,
    parameter int HOLDOFF      = 2,
    localparam int CH_W    = (NB_RECEIVERS > 1) ? $clog2(NB_RECEIVERS) : 1,
    localparam int ENTRY_W = CH_W + DATA_WIDTH + TS_WIDTH
) (
    input  logic                               clk_96MHz,
    input  logic                               reset_n,
    input  logic [NB_RECEIVERS*DATA_WIDTH-1:0] decoded_data,
    input  logic [NB_RECEIVERS*TS_WIDTH-1:0]   ts_decoded_data,
    input  logic [NB_RECEIVERS-1:0]            decoded_data_avl,
    output logic [NB_RECEIVERS-1:0]            reset_bmc_decoder,
    input  logic [7:0]                         block_wanted_number,
    input  logic                               block_pop,
    output logic [ENTRY_W-1:0]                 block_wanted,
    output logic                               data_ready,
    output logic [7:0]                         avl_blocks_nb,
    output logic [7:0]                         overflow_cnt
);

    localparam int AW   = $clog2(DEPTH);
    localparam int HO_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [HO_W-1:0]         holdoff [NB_RECEIVERS];
    logic [NB_RECEIVERS-1:0] eligible;
    logic [CH_W-1:0]         last_grant;
    logic [CH_W-1:0]         gnt_ch;
    logic [CH_W-1:0]         cand;
    logic                    gnt_valid;

    logic                    wr_pending;
    logic [ENTRY_W-1:0]      wr_entry;
    logic [ENTRY_W-1:0]      mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW:0]             count;
    logic [ENTRY_W-1:0]      rd_data;
    logic                    rd_valid;

    logic                    full;
    logic                    do_pop;
    logic                    lost;
    logic                    wr_en;
    logic                    drop_rd;

    always_comb begin
        for (int i = 0; i < NB_RECEIVERS; i++) begin
            eligible[i] = decoded_data_avl[i] && (holdoff[i] == '0);
        end
    end

    // Candidates are visited from farthest to nearest after last_grant,
    // so the last hit is the nearest eligible channel.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_ch    = '0;
        cand      = '0;
        for (int k = NB_RECEIVERS; k >= 1; k--) begin
            cand = CH_W'((int'(last_grant) + k) % NB_RECEIVERS);
            if (eligible[cand]) begin
                gnt_valid = 1'b1;
                gnt_ch    = cand;
            end
        end
    end

    // A pop at full frees the slot the pending word needs, so only a
    // full buffer without a pop loses a word.
    always_comb begin
        full    = (count == FULL_CNT);
        do_pop  = block_pop && (count != '0);
        lost    = wr_pending && full && !do_pop;
        drop_rd = lost && DROP_OLDEST;
        wr_en   = wr_pending && (!lost || DROP_OLDEST);
    end

    assign avl_blocks_nb = 8'(count);
    assign data_ready    = rd_valid;
    assign block_wanted  = rd_valid ? rd_data : '0;

    always_ff @(posedge clk_96MHz or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NB_RECEIVERS; i++) begin
                holdoff[i] <= '0;
            end
            last_grant        <= CH_W'(NB_RECEIVERS - 1);
            reset_bmc_decoder <= '0;
            wr_pending        <= 1'b0;
            wr_entry          <= '0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            overflow_cnt      <= '0;
            rd_valid          <= 1'b0;
        end else begin
            reset_bmc_decoder <= '0;
            for (int i = 0; i < NB_RECEIVERS; i++) begin
                if (gnt_valid && int'(gnt_ch) == i) begin
                    holdoff[i] <= HO_W'(HOLDOFF);
                end else if (holdoff[i] != '0) begin
                    holdoff[i] <= holdoff[i] - 1'b1;
                end
            end
            wr_pending <= gnt_valid;
            if (gnt_valid) begin
                reset_bmc_decoder[gnt_ch] <= 1'b1;
                last_grant <= gnt_ch;
                wr_entry   <= {gnt_ch,
                    decoded_data[int'(gnt_ch)*DATA_WIDTH +: DATA_WIDTH],
                    ts_decoded_data[int'(gnt_ch)*TS_WIDTH +: TS_WIDTH]};
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop || drop_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !do_pop && !drop_rd) begin
                count <= count + 1'b1;
            end else if (do_pop && !wr_en) begin
                count <= count - 1'b1;
            end
            if (lost && overflow_cnt != 8'hFF) begin
                overflow_cnt <= overflow_cnt + 1'b1;
            end
            rd_valid <= (block_wanted_number < avl_blocks_nb);
        end
    end

    // Plain write port and registered read port for block-RAM mapping.
    always_ff @(posedge clk_96MHz) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_entry;
        end
        rd_data <= mem[rd_ptr + block_wanted_number[AW-1:0]];
    end

endmodule

// File: doc/multi_receiver_collector.md
# multi_receiver_collector

Parametrised, multi-channel successor to the single-receiver RAM stage. It collects decoded lighthouse words from NB_RECEIVERS independent BMC decoders through a round-robin arbiter. Each word is tagged with its channel index and pushed into one shared circular buffer. The host reads any buffered block by index and retires blocks with an explicit pop. The block sits between the per-receiver decoders and the host-facing register interface.

## Interface
Parameters:
- NB_RECEIVERS, 4: number of decoder channels, 2..16.
- DATA_WIDTH, 17: decoded word width.
- TS_WIDTH, 24: timestamp width.
- DEPTH, 32: buffer entries, power of two, 4..128.
- DROP_OLDEST, 0: overflow policy. 0 = discard incoming word; 1 = overwrite oldest entry.
- HOLDOFF, 2: cycles a channel stays masked after grant.

Derived:
- CH_W = max(1, clog2(NB_RECEIVERS)).
- ENTRY_W = CH_W + DATA_WIDTH + TS_WIDTH.

Ports:
- clk_96MHz  in  1  single system clock.
- reset_n  in  1  asynchronous active-low reset.
- decoded_data  in  NB_RECEIVERS*DATA_WIDTH  per-channel words, channel 0 in LSBs.
- ts_decoded_data  in  NB_RECEIVERS*TS_WIDTH  per-channel timestamps, same packing.
- decoded_data_avl  in  NB_RECEIVERS  per-channel level "word valid", held until cleared.
- reset_bmc_decoder  out  NB_RECEIVERS  one-cycle clear pulse to the granted decoder.
- block_wanted_number  in  8  read index; 0 = oldest entry.
- block_pop  in  1  retire the oldest entry.
- block_wanted  out  ENTRY_W  {channel, data, ts}, MSB to LSB.
- data_ready  out  1  block_wanted holds a valid entry.
- avl_blocks_nb  out  8  current occupancy.
- overflow_cnt  out  8  saturating count of lost words.

## Operation
- Eligibility: channel i is eligible when decoded_data_avl[i]=1 and its holdoff counter is 0.
- Arbiter: round-robin over eligible channels. Search starts at last_grant+1 and wraps modulo NB_RECEIVERS. At most one grant per cycle.
- On a grant to channel c in cycle N:
  - Register entry {c, data_c, ts_c}.
  - Pulse reset_bmc_decoder[c] high during cycle N+1 only.
  - Load holdoff_c with HOLDOFF; it decrements to 0 one per cycle.
  - Set last_grant = c.
- Write path: the entry is written at wr_ptr in cycle N+1.
  - Not full: wr_ptr++, count++.
  - Full, DROP_OLDEST=0: entry discarded, overflow_cnt++.
  - Full, DROP_OLDEST=1: entry written over the oldest, wr_ptr++, rd_ptr++, count unchanged, overflow_cnt++.
  - The decoder is cleared on grant in every case, so it is never stalled.
- Pop: block_pop=1 with count>0 gives rd_ptr++, count--. Pop while empty is ignored and does not change overflow_cnt.
- Write and pop in the same cycle:
  - Not full: count unchanged, both pointers advance.
  - Full: the pop frees a slot, so the write is accepted with no overflow under either policy.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits, zero-extended onto avl_blocks_nb.
- Read: block_wanted = mem[rd_ptr + block_wanted_number], index taken modulo DEPTH, registered.
  - data_ready = (block_wanted_number < count), registered in the same cycle as block_wanted.
  - When data_ready=0, block_wanted is all zeros.
- overflow_cnt saturates at 255. It is cleared only by reset.
- Storage is inferable as BRAM: one write port, one registered read port.

## Timing
- Reset (asynchronous assert, synchronous release):
  - Pointers, count, holdoff counters and last_grant = NB_RECEIVERS-1 (so channel 0 is searched first) all reset.
  - reset_bmc_decoder=0, block_wanted=0, data_ready=0, avl_blocks_nb=0, overflow_cnt=0.
- Reset mid-operation discards all buffered entries. Any in-flight clear pulse is dropped; the decoder keeps its word and is re-granted after release.
- Latencies:
  - Grant to reset_bmc_decoder pulse: 1 cycle.
  - Grant to avl_blocks_nb increment: 2 cycles; count updates at the end of cycle N+1.
  - block_wanted_number or buffer change to block_wanted/data_ready: 1 cycle.
  - block_pop to avl_blocks_nb decrement: 1 cycle.
- HOLDOFF >= 2 covers the decoder's 1-cycle clear latency. A channel cannot be re-granted earlier than N+HOLDOFF+1.
- Sustained throughput is one word per cycle across channels. The worst-case wait for a single channel is NB_RECEIVERS-1 grants.

## Test plan
- Single word:
  - Stimulus: channel 2 presents data 17'h1ABCD, ts 24'h000100; decoded_data_avl[2] rises at cycle 10.
  - Required: reset_bmc_decoder[2] pulses at 11 only; avl_blocks_nb=1 at 12; index 0 gives block_wanted={2,17'h1ABCD,24'h000100} with data_ready=1.
- Fairness:
  - Stimulus: all 4 channels held valid continuously (decoder model clears 1 cycle after pulse, re-asserts 3 cycles later).
  - Required: grant order 0,1,2,3,0,…; no channel is granted twice before the other three.
- Overflow, DROP_OLDEST=0, DEPTH=4:
  - Stimulus: 6 words, no pop.
  - Required: avl_blocks_nb=4; overflow_cnt=2; indices 0..3 return the first 4 words; all 6 clear pulses are issued.
- Overflow, DROP_OLDEST=1, DEPTH=4:
  - Stimulus: same as above.
  - Required: indices 0..3 return words 3..6; overflow_cnt=2.
- Simultaneous write and pop at full (DEPTH=4):
  - Required: count stays 4; overflow_cnt unchanged; oldest advances.
- Empty and index bounds:
  - Pop while empty: count stays 0.
  - Index 5 with count=3: data_ready=0 and block_wanted=0.
- Reset mid-run:
  - Stimulus: assert reset_n=0 with count=3.
  - Required: all outputs 0 immediately. After release, still-pending decoders are re-granted starting from channel 0.
